adder_station: RTL and testbench
================================

ADDER_STATION -- requirements
Module: adder_station

Interface
REQ-001 Parameters: FU_ID (default ADDER_START), the FU slot this station answers to; EXEC_LAT (default 2), execute latency in clk cycles, legal 1..15.
REQ-002 clk  input  1  clock; reset  input  1  reset, asynchronous, active-high.
REQ-003 kill  input  1  this station's reset_out bit from the reorder buffer; asynchronous flush.
REQ-004 CDB_inst_fu  input  FU_INDEX  target FU of the instruction issued this cycle; NO_FU means none.
REQ-005 CDB_inst_inst  input  WORD_SIZE  issued instruction: op[31:28], rd[27:24], rs[23:20], rt[19:16], imm[15:0].
REQ-006 CDB_inst_RBindex  input  RB_INDEX  ROB slot of the issued instruction.
REQ-007 numj, numk  output  REG_INDEX each  register-status/regfile lookup indices, combinational rs and rt of CDB_inst_inst.
REQ-008 qj, qk  input  RB_INDEX each  producer ROB slot or READY; vj, vk  input  WORD_SIZE each  regfile values.
REQ-009 CDB_data_data_in  input  RB_SIZE*WORD_SIZE; CDB_data_valid_in  input  RB_SIZE  OR-combined result bus, snooped.
REQ-010 data_out  output  RB_SIZE*WORD_SIZE; valid_out  output  RB_SIZE  this station's bus contribution, zero outside its own slot.
REQ-011 busy  output  1  station cannot accept an instruction.

Function
REQ-012 States: IDLE, WAIT_OPS, EXEC, DONE; state, operands and counters update on negedge clk.
REQ-013 Accept at a negedge when CDB_inst_fu==FU_ID and state is IDLE or DONE; latch op, rd slot (CDB_inst_RBindex), qj/vj, qk/vk.
REQ-014 busy is 1 in WAIT_OPS and EXEC, 0 in IDLE and DONE; it rises at the accepting negedge, so the ROB's next posedge sees it.
REQ-015 ADDI/SUBI use sign-extended imm as operand k (treated READY); qk ignored.
REQ-016 Operand with q!=READY is captured at any negedge where CDB_data_valid_in[q]==1, taking word q of CDB_data_data_in.
REQ-017 WAIT_OPS -> EXEC at the negedge both operands are ready; EXEC counts EXEC_LAT negedges then -> DONE.
REQ-018 Result: ADD/ADDI j+k, SUB/SUBI j-k, modulo 2^32, no overflow flag.
REQ-019 In DONE: valid_out bit [slot]=1 and data_out word [slot]=result; held until the next accept, kill or reset.
REQ-020 Accept while in DONE: result retracted at that same negedge, new instruction enters WAIT_OPS or EXEC.
REQ-021 Unsupported opcode with CDB_inst_fu==FU_ID: ignored, state unchanged.
REQ-022 kill high: immediately IDLE, busy=0, valid_out=0, data_out=0; an accept coinciding with kill is dropped.

Reset
REQ-023 reset high: state IDLE, busy=0, valid_out=0, data_out=0, operand registers and counters 0; reset dominates kill and accept.

Configuration
REQ-024 Macro ADDER_STATION_BYPASS_EN: if defined, operands whose producer is valid on CDB_data_valid_in at the accepting negedge are captured then; if both are ready, the station enters EXEC directly.
REQ-025 Without ADDER_STATION_BYPASS_EN, every accept enters WAIT_OPS; operand capture starts at the following negedge.
REQ-026 Accept-to-DONE latency: EXEC_LAT negedges with the macro; EXEC_LAT+1 without it, when operands are already READY.

Verification
REQ-027 ADD r3=r1+r2, qj=qk=READY, vj=5, vk=7, slot 4, EXEC_LAT=2 -> valid_out=0x0010, word4=12, after 2 negedges (macro on) or 3 (off).
REQ-028 SUBI rs=READY vj=3, imm=0xFFFF -> result 4; SUB vj=0, vk=1 -> 0xFFFFFFFF.
REQ-029 ADD qj=slot 2 pending; slot 2 valid with 100 two cycles later, vk=1 -> busy held until DONE, result 101.
REQ-030 kill pulse 0.1 in EXEC -> busy=0 and valid_out=0 immediately; the next issue is accepted normally.
REQ-031 DONE in slot 6, new ADD issued to FU_ID in slot 7 -> bit 6 drops and bit 7 rises after the computed latency.
REQ-032 reset asserted in WAIT_OPS with a CDB match -> all outputs 0, no operand captured.

Source files
------------

// File: rtl/adder_station.sv
// Reservation station for the integer adder FU: ADD, SUB, ADDI, SUBI.
// Latency: accept-to-DONE is EXEC_LAT negedges with ADDER_STATION_BYPASS_EN defined, EXEC_LAT+1 without it (operands READY).
// Backpressure: busy is high in WAIT_OPS/EXEC; the result is held on the bus until the next accept, kill or reset.
module adder_station #(
  parameter int               FU_W        = 3,
  parameter logic [FU_W-1:0]  ADDER_START = 3'd1,         // FU code 0 is NO_FU
  parameter logic [FU_W-1:0]  FU_ID       = ADDER_START,
  parameter int               EXEC_LAT    = 2,            // 1..15
  parameter int               WORD_SIZE   = 32,
  parameter int               RB_SIZE     = 16,           // power of two
  parameter int               REG_W       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         kill,
  input  logic [FU_W-1:0]              CDB_inst_fu,
  input  logic [WORD_SIZE-1:0]         CDB_inst_inst,
  input  logic [$clog2(RB_SIZE):0]     CDB_inst_RBindex,
  output logic [REG_W-1:0]             numj,
  output logic [REG_W-1:0]             numk,
  input  logic [$clog2(RB_SIZE):0]     qj,
  input  logic [$clog2(RB_SIZE):0]     qk,
  input  logic [WORD_SIZE-1:0]         vj,
  input  logic [WORD_SIZE-1:0]         vk,
  input  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data_in,
  input  logic [RB_SIZE-1:0]           CDB_data_valid_in,
  output logic [RB_SIZE*WORD_SIZE-1:0] data_out,
  output logic [RB_SIZE-1:0]           valid_out,
  output logic                         busy
);
  // Tags carry one extra bit above the slot index; READY is the value RB_SIZE,
  // so any tag with the top bit set means "value already present".
  localparam int                SLOT_W = $clog2(RB_SIZE);
  localparam int                RB_W   = SLOT_W + 1;
  localparam logic [RB_W-1:0]   READY  = RB_W'(RB_SIZE);
  localparam logic [3:0]        LAST   = 4'(EXEC_LAT - 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;

  typedef enum logic [1:0] {IDLE, WAIT_OPS, EXEC, DONE} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             op_q, op_nxt;
  logic [SLOT_W-1:0]      slot_q, slot_nxt;
  logic [RB_W-1:0]        qj_q, qj_nxt, qk_q, qk_nxt;
  logic [WORD_SIZE-1:0]   vj_q, vj_nxt, vk_q, vk_nxt;
  logic [3:0]             cnt_q, cnt_nxt;

  logic [3:0]             in_op;
  logic                   in_supported, in_imm, accept;
  logic [RB_W-1:0]        k_tag_in;
  logic [WORD_SIZE-1:0]   k_val_in, result;
  logic                   unused_bits;

  function automatic logic tag_hit(input logic [RB_W-1:0] q, input logic [RB_SIZE-1:0] v);
    return !q[SLOT_W] && v[q[SLOT_W-1:0]];
  endfunction

  function automatic logic [WORD_SIZE-1:0] tag_word(input logic [RB_W-1:0] q,
                                                    input logic [RB_SIZE*WORD_SIZE-1:0] d);
    return d[q[SLOT_W-1:0]*WORD_SIZE +: WORD_SIZE];
  endfunction

  assign numj         = CDB_inst_inst[23:20];
  assign numk         = CDB_inst_inst[19:16];
  assign in_op        = CDB_inst_inst[31:28];
  assign in_imm       = (in_op == OP_ADDI) || (in_op == OP_SUBI);
  assign in_supported = (in_op == OP_ADD) || (in_op == OP_SUB) || in_imm;
  assign accept       = (CDB_inst_fu == FU_ID) && in_supported && ((state == IDLE) || (state == DONE));
  // Immediate forms take the sign-extended imm as an already-present k operand.
  assign k_tag_in     = in_imm ? READY : qk;
  assign k_val_in     = in_imm ? {{(WORD_SIZE-16){CDB_inst_inst[15]}}, CDB_inst_inst[15:0]} : vk;
  assign result       = ((op_q == OP_SUB) || (op_q == OP_SUBI)) ? (vj_q - vk_q) : (vj_q + vk_q);
  assign busy         = (state == WAIT_OPS) || (state == EXEC);
  assign unused_bits  = ^{CDB_inst_inst[27:24], CDB_inst_RBindex[SLOT_W]};

  // Next-state and datapath: accept, operand snoop, execute countdown.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    slot_nxt  = slot_q;
    qj_nxt    = qj_q;
    vj_nxt    = vj_q;
    qk_nxt    = qk_q;
    vk_nxt    = vk_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          op_nxt    = in_op;
          slot_nxt  = CDB_inst_RBindex[SLOT_W-1:0];
          qj_nxt    = qj;
          vj_nxt    = vj;
          qk_nxt    = k_tag_in;
          vk_nxt    = k_val_in;
          cnt_nxt   = '0;
          state_nxt = WAIT_OPS;
`ifdef ADDER_STATION_BYPASS_EN
          if (tag_hit(qj, CDB_data_valid_in)) begin
            qj_nxt = READY;
            vj_nxt = tag_word(qj, CDB_data_data_in);
          end
          if (tag_hit(k_tag_in, CDB_data_valid_in)) begin
            qk_nxt = READY;
            vk_nxt = tag_word(k_tag_in, CDB_data_data_in);
          end
          if (qj_nxt[SLOT_W] && qk_nxt[SLOT_W]) state_nxt = EXEC;
`endif
        end
      end
      WAIT_OPS: begin
        if (tag_hit(qj_q, CDB_data_valid_in)) begin
          qj_nxt = READY;
          vj_nxt = tag_word(qj_q, CDB_data_data_in);
        end
        if (tag_hit(qk_q, CDB_data_valid_in)) begin
          qk_nxt = READY;
          vk_nxt = tag_word(qk_q, CDB_data_data_in);
        end
        if (qj_nxt[SLOT_W] && qk_nxt[SLOT_W]) begin
          state_nxt = EXEC;
          cnt_nxt   = '0;
        end
      end
      EXEC: begin
        if (cnt_q == LAST) state_nxt = DONE;
        else               cnt_nxt   = cnt_q + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and operand registers on the falling edge; reset beats kill, kill drops any accept.
  always_ff @(negedge clk or posedge reset or posedge kill) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      slot_q <= '0;
      qj_q   <= '0;
      vj_q   <= '0;
      qk_q   <= '0;
      vk_q   <= '0;
      cnt_q  <= '0;
    end else if (kill) begin
      state  <= IDLE;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      slot_q <= slot_nxt;
      qj_q   <= qj_nxt;
      vj_q   <= vj_nxt;
      qk_q   <= qk_nxt;
      vk_q   <= vk_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Result bus contribution: only this station's slot, only while DONE.
  always_comb begin
    valid_out = '0;
    data_out  = '0;
    if (state == DONE) begin
      valid_out[slot_q]                       = 1'b1;
      data_out[slot_q*WORD_SIZE +: WORD_SIZE] = result;
    end
  end
endmodule

// File: tb/tb_adder_station.sv
// Directed plus randomized checks of adder_station against a plain-arithmetic model.
module tb_adder_station;
  localparam int         LAT   = 2;
  localparam logic [2:0] FU    = 3'd1;
  localparam logic [2:0] NO_FU = 3'd0;
  localparam logic [4:0] RDY   = 5'h10;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, ADDI = 4'h2, SUBI = 4'h3;
`ifdef ADDER_STATION_BYPASS_EN
  localparam int ISSUE_LAT = LAT;
`else
  localparam int ISSUE_LAT = LAT + 1;
`endif

  logic         clk = 1'b0;
  logic         reset, kill;
  logic [2:0]   CDB_inst_fu;
  logic [31:0]  CDB_inst_inst;
  logic [4:0]   CDB_inst_RBindex;
  logic [3:0]   numj, numk;
  logic [4:0]   qj, qk;
  logic [31:0]  vj, vk;
  logic [511:0] CDB_data_data_in;
  logic [15:0]  CDB_data_valid_in;
  logic [511:0] data_out;
  logic [15:0]  valid_out;
  logic         busy;

  int nchk = 0, npass = 0, nfail = 0;

  adder_station #(.EXEC_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .CDB_inst_fu(CDB_inst_fu), .CDB_inst_inst(CDB_inst_inst), .CDB_inst_RBindex(CDB_inst_RBindex),
    .numj(numj), .numk(numk), .qj(qj), .qk(qk), .vj(vj), .vk(vk),
    .CDB_data_data_in(CDB_data_data_in), .CDB_data_valid_in(CDB_data_valid_in),
    .data_out(data_out), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the instruction's meaning, wrapped to 32 bits.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [15:0] imm);
    longint x, y, r;
    x = longint'(a);
    y = (op == ADDI || op == SUBI) ? longint'($signed(imm)) : longint'(b);
    r = (op == SUB || op == SUBI) ? x - y : x + y;
    return 32'(r);
  endfunction

  function automatic logic [31:0] word(input int s);
    return data_out[s*32 +: 32];
  endfunction

  task automatic issue(input logic [2:0] fu, input logic [3:0] op, input logic [15:0] imm,
                       input int slot, input logic [4:0] tj, input logic [31:0] aj,
                       input logic [4:0] tk, input logic [31:0] ak);
    logic [3:0] rs, rt;
    rs = 4'($urandom_range(0, 15));
    rt = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    CDB_inst_fu      = fu;
    CDB_inst_inst    = {op, 4'(slot), rs, rt, imm};
    CDB_inst_RBindex = 5'(slot);
    qj = tj; vj = aj; qk = tk; vk = ak;
    #1;
    chk("numj", 32'(numj), 32'(rs));
    chk("numk", 32'(numk), 32'(rt));
    @(negedge clk); #1;
    CDB_inst_fu = NO_FU;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (valid_out == 16'd0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic broadcast(input int s, input logic [31:0] val);
    @(posedge clk); #1;
    CDB_data_valid_in = 16'd1 << s;
    CDB_data_data_in  = '0;
    CDB_data_data_in[s*32 +: 32] = val;
    @(posedge clk); #1;
    CDB_data_valid_in = '0;
    CDB_data_data_in  = '0;
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [15:0] imm;
    int slot, src, dly;
    logic pend;
    logic [4:0] tk;

    reset = 1'b1; kill = 1'b0; CDB_inst_fu = NO_FU; CDB_inst_inst = '0; CDB_inst_RBindex = '0;
    qj = RDY; qk = RDY; vj = '0; vk = '0; CDB_data_data_in = '0; CDB_data_valid_in = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_data", 32'(|data_out), 0);
    @(posedge clk); #1 reset = 1'b0;

    // ADD 5+7 into slot 4
    issue(FU, ADD, 16'h0, 4, RDY, 32'd5, RDY, 32'd7);
    chk("add_busy", 32'(busy), 1);
    wait_done(n);
    chk("add_lat", n, ISSUE_LAT);
    chk("add_valid", 32'(valid_out), 32'h10);
    chk("add_word", word(4), 32'd12);
    chk("add_busy_done", 32'(busy), 0);

    // SUBI 3 - (-1) issued while DONE: retract then new result
    issue(FU, SUBI, 16'hFFFF, 1, RDY, 32'd3, 5'd9, 32'hDEAD);
    chk("subi_retract", 32'(valid_out), 0);
    chk("subi_busy", 32'(busy), 1);
    wait_done(n);
    chk("subi_lat", n, ISSUE_LAT);
    chk("subi_word", word(1), 32'd4);

    issue(FU, SUB, 16'h0, 2, RDY, 32'd0, RDY, 32'd1);
    wait_done(n);
    chk("sub_word", word(2), 32'hFFFF_FFFF);
    chk("sub_valid", 32'(valid_out), 32'h4);

    // ADD with j pending on slot 2
    issue(FU, ADD, 16'h0, 5, 5'd2, 32'h1234, RDY, 32'd1);
    cycles(2);
    chk("pend_busy", 32'(busy), 1);
    chk("pend_valid", 32'(valid_out), 0);
    broadcast(2, 32'd100);
    wait_done(n);
    chk("pend_valid_done", 32'(valid_out), 32'h20);
    chk("pend_word", word(5), 32'd101);
    chk("pend_busy_done", 32'(busy), 0);

    // kill pulse during execution
    issue(FU, ADD, 16'h0, 3, RDY, 32'd1, RDY, 32'd2);
    @(negedge clk); #2;
    kill = 1'b1; #1;
    chk("kill_busy", 32'(busy), 0);
    chk("kill_valid", 32'(valid_out), 0);
    chk("kill_data", 32'(|data_out), 0);
    kill = 1'b0;
    cycles(4);
    chk("kill_stays_idle", 32'(valid_out), 0);
    issue(FU, ADD, 16'h0, 3, RDY, 32'd40, RDY, 32'd2);
    wait_done(n);
    chk("after_kill_lat", n, ISSUE_LAT);
    chk("after_kill_word", word(3), 32'd42);

    // accept coinciding with kill is dropped
    kill = 1'b1;
    issue(FU, ADD, 16'h0, 8, RDY, 32'd1, RDY, 32'd1);
    kill = 1'b0;
    chk("kill_accept_busy", 32'(busy), 0);
    cycles(4);
    chk("kill_accept_valid", 32'(valid_out), 0);

    // DONE in slot 6, then new ADD in slot 7
    issue(FU, ADD, 16'h0, 6, RDY, 32'd10, RDY, 32'd20);
    wait_done(n);
    cycles(3);
    chk("hold_valid", 32'(valid_out), 32'h40);
    chk("hold_word", word(6), 32'd30);
    issue(FU, ADD, 16'h0, 7, RDY, 32'd7, RDY, 32'd8);
    chk("s7_retract", 32'(valid_out), 0);
    wait_done(n);
    chk("s7_lat", n, ISSUE_LAT);
    chk("s7_valid", 32'(valid_out), 32'h80);
    chk("s7_word", word(7), 32'd15);

    // unsupported opcode and foreign FU are ignored
    issue(FU, 4'h7, 16'h0, 9, RDY, 32'd1, RDY, 32'd1);
    chk("badop_busy", 32'(busy), 0);
    chk("badop_valid", 32'(valid_out), 32'h80);
    issue(3'd2, ADD, 16'h0, 9, RDY, 32'd1, RDY, 32'd1);
    chk("otherfu_busy", 32'(busy), 0);
    chk("otherfu_valid", 32'(valid_out), 32'h80);

    // reset during WAIT_OPS with a matching broadcast
    issue(FU, ADD, 16'h0, 9, 5'd3, 32'd0, RDY, 32'd5);
    @(posedge clk); #1;
    reset = 1'b1;
    CDB_data_valid_in = 16'h0008;
    CDB_data_data_in[3*32 +: 32] = 32'd55;
    #1;
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_valid", 32'(valid_out), 0);
    @(negedge clk); #1;
    chk("rstw_data", 32'(|data_out), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    CDB_data_valid_in = '0;
    CDB_data_data_in  = '0;
    cycles(4);
    chk("rstw_idle_valid", 32'(valid_out), 0);
    chk("rstw_idle_busy", 32'(busy), 0);

    // randomized transactions
    for (int it = 0; it < 30; it++) begin
      op   = 4'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      imm  = 16'($urandom);
      slot = $urandom_range(0, 15);
      pend = 1'($urandom_range(0, 1));
      src  = $urandom_range(0, 15);
      dly  = $urandom_range(0, 3);
      tk   = (op == ADDI || op == SUBI) ? 5'($urandom_range(0, 15)) : RDY;
      issue(FU, op, imm, slot, pend ? 5'(src) : RDY, pend ? ~a : a, tk, b);
      if (pend) begin
        cycles(dly);
        chk("rnd_wait_valid", 32'(valid_out), 0);
        broadcast(src, a);
      end
      wait_done(n);
      if (!pend) chk("rnd_lat", n, ISSUE_LAT);
      chk("rnd_valid", 32'(valid_out), 32'(16'd1 << slot));
      chk("rnd_word", word(slot), model(op, a, b, imm));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
